// File: rtl/dumbrv_wb_sched_pkg.sv
// Shared types and constants for the dumbrv writeback scheduler.
package dumbrv_wb_sched_pkg;

  // Source tags carried in each queued entry.
  localparam logic SRC_EX = 1'b0;
  localparam logic SRC_LD = 1'b1;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // One queued writeback: where it came from, target register, data.
  typedef struct packed {
    logic        src;
    logic [3:0]  rd;
    logic [31:0] value;
  } wb_entry_t;

  // One-hot decode of a register index; x0 never counts as busy.
  function automatic logic [15:0] reg_onehot(input logic [3:0] r);
    logic [15:0] oh;
    oh    = 16'd1 << r;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/dumbrv_wb_fifo.sv
// Writeback FIFO: in-order storage of pending register-file writes.
module dumbrv_wb_fifo
  import dumbrv_wb_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  wb_entry_t               push_data_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [DEPTH-1:0][3:0]   entry_reg_o,
  output logic [DEPTH-1:0]        entry_valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Storage, power-of-two pointers that wrap naturally, and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Expose each slot's register and whether it currently holds a live entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_reg_o[i]   = mem_q[i].rd;
      entry_valid_o[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dumbrv_wb_sched.sv
// Writeback scheduler: arbitrates execute/load results into a FIFO and
// issues them one at a time to the two register-file write ports.
module dumbrv_wb_sched
  import dumbrv_wb_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_reg,
  input  logic [31:0] ex_value,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_reg,
  input  logic [31:0] ld_value,
  output logic [3:0]  rf_wr1_reg,
  output logic [31:0] rf_wr1_value,
  input  logic        rf_wr1_done,
  output logic [3:0]  rf_wr2_reg,
  output logic [31:0] rf_wr2_value,
  input  logic        rf_wr2_done,
  output logic [15:0] busy_mask,
  output logic        idle,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 started_q;
  logic                 err_q, err_d;
  wb_entry_t            head;
  wb_entry_t            push_data;
  logic [CW-1:0]        count;
  logic [DEPTH-1:0][3:0] entry_reg;
  logic [DEPTH-1:0]     entry_valid;
  logic                 push;
  logic                 pop;
  logic                 avail;
  logic                 grant_ex;
  logic                 grant_ld;
  logic                 any_done;
  logic                 done_match;
  logic                 done_other;

  dumbrv_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .entry_reg_o  (entry_reg),
    .entry_valid_o(entry_valid)
  );

  // Round-robin arbitration on the registered count; x0 writes are granted but dropped.
  always_comb begin
    avail     = started_q && (count != CW'(DEPTH));
    grant_ld  = avail && ld_valid && (!ex_valid || (rr_q == SRC_LD));
    grant_ex  = avail && ex_valid && (!ld_valid || (rr_q == SRC_EX));
    rr_d      = rr_q;
    push      = 1'b0;
    push_data = '0;
    if (ex_valid && ld_valid && avail) begin
      rr_d = grant_ld ? SRC_EX : SRC_LD;
    end
    if (grant_ld) begin
      push_data = '{src: SRC_LD, rd: ld_reg, value: ld_value};
      push      = (ld_reg != 4'd0);
    end else if (grant_ex) begin
      push_data = '{src: SRC_EX, rd: ex_reg, value: ex_value};
      push      = (ex_reg != 4'd0);
    end
  end

  assign ex_ready = grant_ex;
  assign ld_ready = grant_ld;

  // Issue FSM next state, port drive, pop and protocol-error detection.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    err_d        = err_q;
    rf_wr1_reg   = '0;
    rf_wr1_value = '0;
    rf_wr2_reg   = '0;
    rf_wr2_value = '0;
    any_done     = rf_wr1_done || rf_wr2_done;
    done_match   = (head.src == SRC_EX) ? rf_wr1_done : rf_wr2_done;
    done_other   = (head.src == SRC_EX) ? rf_wr2_done : rf_wr1_done;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) state_d = ST_ISSUE;
        if (any_done) err_d = 1'b1;
      end
      ST_ISSUE: begin
        if (head.src == SRC_EX) begin
          rf_wr1_reg   = head.rd;
          rf_wr1_value = head.value;
        end else begin
          rf_wr2_reg   = head.rd;
          rf_wr2_value = head.value;
        end
        state_d = ST_WAIT;
        if (any_done) err_d = 1'b1;
      end
      ST_WAIT: begin
        if (head.src == SRC_EX) rf_wr1_value = head.value;
        else                    rf_wr2_value = head.value;
        if (done_match) begin
          state_d = ST_GAP;
          pop     = 1'b1;
        end
        if (done_other) err_d = 1'b1;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        if (any_done) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy registers: every live FIFO slot, which includes the in-flight head.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy_mask = busy_mask | reg_onehot(entry_reg[i]);
    end
  end

  assign idle = (count == '0) && (state_q == ST_IDLE);
  assign err  = err_q;

  // State, arbitration pointer, post-reset ready enable and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_q      <= SRC_LD;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      started_q <= 1'b1;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dumbrv_wb_sched.sv
// Directed testbench for dumbrv_wb_sched with a simple register-file responder.
module tb_dumbrv_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  ex_reg = '0;
  logic [31:0] ex_value = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [3:0]  ld_reg = '0;
  logic [31:0] ld_value = '0;
  logic [3:0]  rf_wr1_reg;
  logic [31:0] rf_wr1_value;
  logic        rf_wr1_done = 1'b0;
  logic [3:0]  rf_wr2_reg;
  logic [31:0] rf_wr2_value;
  logic        rf_wr2_done = 1'b0;
  logic [15:0] busy_mask;
  logic        idle;
  logic        err;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          auto_done = 1'b1;
  bit          pend1 = 1'b0;
  bit          pend2 = 1'b0;
  int          log_port[$];
  int          log_reg[$];
  int          log_cyc[$];
  logic [31:0] log_val[$];
  logic [31:0] rf[16];

  dumbrv_wb_sched #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_reg      (ex_reg),
    .ex_value    (ex_value),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_reg      (ld_reg),
    .ld_value    (ld_value),
    .rf_wr1_reg  (rf_wr1_reg),
    .rf_wr1_value(rf_wr1_value),
    .rf_wr1_done (rf_wr1_done),
    .rf_wr2_reg  (rf_wr2_reg),
    .rf_wr2_value(rf_wr2_value),
    .rf_wr2_done (rf_wr2_done),
    .busy_mask   (busy_mask),
    .idle        (idle),
    .err         (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance to the next negedge, log any issue seen, and answer it one cycle later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (rf_wr1_reg != 4'd0) begin
      log_port.push_back(1);
      log_reg.push_back(int'(rf_wr1_reg));
      log_val.push_back(rf_wr1_value);
      log_cyc.push_back(cyc);
      rf[rf_wr1_reg] = rf_wr1_value;
    end
    if (rf_wr2_reg != 4'd0) begin
      log_port.push_back(2);
      log_reg.push_back(int'(rf_wr2_reg));
      log_val.push_back(rf_wr2_value);
      log_cyc.push_back(cyc);
      rf[rf_wr2_reg] = rf_wr2_value;
    end
    if (auto_done) begin
      rf_wr1_done = pend1;
      rf_wr2_done = pend2;
      pend1 = (rf_wr1_reg != 4'd0);
      pend2 = (rf_wr2_reg != 4'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 1'b0; ld_valid = 1'b0;
    ex_reg = '0; ld_reg = '0; ex_value = '0; ld_value = '0;
    rf_wr1_done = 1'b0; rf_wr2_done = 1'b0;
    pend1 = 1'b0; pend2 = 1'b0;
    auto_done = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ex_valid = 1'b1; ld_valid = 1'b1; ex_reg = 4'd1; ld_reg = 4'd2;
    #1;
    checks++; if (ex_ready !== 1'b0 || ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got ex=%b ld=%b expected 0/0", ex_ready, ld_ready); end
    checks++; if (rf_wr1_reg !== 4'd0 || rf_wr2_reg !== 4'd0) begin fails++; $display("[TB] FAIL reset_regs: got %h/%h expected 0/0", rf_wr1_reg, rf_wr2_reg); end
    checks++; if (rf_wr1_value !== 32'd0 || rf_wr2_value !== 32'd0) begin fails++; $display("[TB] FAIL reset_values: got %h/%h expected 0/0", rf_wr1_value, rf_wr2_value); end
    checks++; if (busy_mask !== 16'h0000) begin fails++; $display("[TB] FAIL reset_busy: got %h expected 0000", busy_mask); end
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("[TB] FAIL reset_idle_err: got idle=%b err=%b expected 1/0", idle, err); end
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b0 || ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL ready_before_first_edge: got ex=%b ld=%b expected 0/0", ex_ready, ld_ready); end
    cycle();
    ex_valid = 1'b0; ld_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 16'h0000) begin fails++; $display("[TB] FAIL no_accept_first_edge: got busy %h expected 0000", busy_mask); end
    ld_valid = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b1 || ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL ready_after_release: got ld=%b ex=%b expected 1/0", ld_ready, ex_ready); end
    ld_valid = 1'b0;
    #1;
  endtask

  task automatic test_single_ex();
    int base;
    do_reset();
    base = log_port.size();
    ex_valid = 1'b1; ex_reg = 4'd5; ex_value = 32'h1234_5678;
    #1;
    checks++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_ex_ready: got %b expected 1", ex_ready); end
    cycle();
    ex_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 16'h0020 || idle !== 1'b0) begin fails++; $display("[TB] FAIL single_queued: got busy=%h idle=%b expected 0020/0", busy_mask, idle); end
    cycle();
    checks++; if (rf_wr1_reg !== 4'd5 || rf_wr1_value !== 32'h1234_5678 || rf_wr2_reg !== 4'd0) begin fails++; $display("[TB] FAIL single_issue: got wr1=%h/%h wr2=%h expected 5/12345678/0", rf_wr1_reg, rf_wr1_value, rf_wr2_reg); end
    cycle();
    checks++; if (rf_wr1_reg !== 4'd0 || rf_wr1_value !== 32'h1234_5678 || busy_mask !== 16'h0020) begin fails++; $display("[TB] FAIL single_wait: got reg=%h val=%h busy=%h expected 0/12345678/0020", rf_wr1_reg, rf_wr1_value, busy_mask); end
    cycle();
    checks++; if (busy_mask !== 16'h0000 || idle !== 1'b0 || rf_wr1_reg !== 4'd0) begin fails++; $display("[TB] FAIL single_gap: got busy=%h idle=%b reg=%h expected 0000/0/0", busy_mask, idle, rf_wr1_reg); end
    cycle();
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("[TB] FAIL single_idle: got idle=%b err=%b expected 1/0", idle, err); end
    repeat (4) cycle();
    checks++; if (log_port.size() - base !== 1) begin fails++; $display("[TB] FAIL single_pulse_count: got %0d issue cycles expected 1", log_port.size() - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    int diff;
    do_reset();
    base = log_port.size();
    ex_valid = 1'b1; ex_reg = 4'd1; ex_value = 32'h0000_0111;
    ld_valid = 1'b1; ld_reg = 4'd2; ld_value = 32'h0000_0222;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k % 2 == 0) begin
        checks++; if (ld_ready !== 1'b1 || ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_grant_%0d: got ld=%b ex=%b expected 1/0", k, ld_ready, ex_ready); end
      end else begin
        checks++; if (ex_ready !== 1'b1 || ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_grant_%0d: got ex=%b ld=%b expected 1/0", k, ex_ready, ld_ready); end
      end
      cycle();
    end
    #1;
    checks++; if (ex_ready !== 1'b0 || ld_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_full: got ex=%b ld=%b expected 0/0", ex_ready, ld_ready); end
    ex_valid = 1'b0; ld_valid = 1'b0;
    repeat (30) cycle();
    checks++; if (log_port.size() - base !== 5) begin fails++; $display("[TB] FAIL b2b_issue_count: got %0d expected 5", log_port.size() - base); end
    checks++; if (log_port[base] !== 2 || log_reg[base] !== 2 || log_port[base+1] !== 1 || log_reg[base+1] !== 1) begin fails++; $display("[TB] FAIL b2b_order: got port%0d x%0d then port%0d x%0d expected port2 x2 then port1 x1", log_port[base], log_reg[base], log_port[base+1], log_reg[base+1]); end
    diff = log_cyc[base+1] - log_cyc[base];
    checks++; if (!(diff >= 4)) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected at least 4", diff); end
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("[TB] FAIL b2b_end: got idle=%b err=%b expected 1/0", idle, err); end
  endtask

  task automatic test_ordering();
    int base;
    do_reset();
    base = log_port.size();
    ex_valid = 1'b1; ex_reg = 4'd3; ex_value = 32'h0000_000A;
    cycle();
    ex_valid = 1'b0;
    ld_valid = 1'b1; ld_reg = 4'd3; ld_value = 32'h0000_000B;
    #1;
    checks++; if (ld_ready !== 1'b1) begin fails++; $display("[TB] FAIL order_ld_ready: got %b expected 1", ld_ready); end
    cycle();
    ld_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 16'h0008) begin fails++; $display("[TB] FAIL order_busy: got %h expected 0008", busy_mask); end
    repeat (15) cycle();
    checks++; if (log_port.size() - base !== 2) begin fails++; $display("[TB] FAIL order_count: got %0d expected 2", log_port.size() - base); end
    checks++; if (log_port[base] !== 1 || log_val[base] !== 32'hA || log_port[base+1] !== 2 || log_val[base+1] !== 32'hB) begin fails++; $display("[TB] FAIL order_seq: got port%0d=%h then port%0d=%h expected port1=A then port2=B", log_port[base], log_val[base], log_port[base+1], log_val[base+1]); end
    checks++; if (rf[3] !== 32'h0000_000B) begin fails++; $display("[TB] FAIL order_final_x3: got %h expected 0000000b", rf[3]); end
  endtask

  task automatic test_fill();
    int base;
    do_reset();
    auto_done = 1'b0;
    base = log_port.size();
    ex_valid = 1'b1;
    for (int r = 4; r <= 6; r++) begin
      ex_reg = 4'(r); ex_value = 32'(r * 16'h0101);
      #1;
      checks++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready_x%0d: got %b expected 1", r, ex_ready); end
      cycle();
    end
    ex_reg = 4'd7; ex_value = 32'h0707; rf_wr1_done = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_accept_with_pop: got %b expected 1", ex_ready); end
    cycle();
    rf_wr1_done = 1'b0; ex_reg = 4'd8; ex_value = 32'h0808;
    #1;
    checks++; if (ex_ready !== 1'b1 || busy_mask !== 16'h00E0) begin fails++; $display("[TB] FAIL fill_count_kept: got ready=%b busy=%h expected 1/00e0", ex_ready, busy_mask); end
    cycle();
    ex_reg = 4'd9; ex_value = 32'h0909;
    #1;
    checks++; if (ex_ready !== 1'b0 || busy_mask !== 16'h01E0) begin fails++; $display("[TB] FAIL fill_full: got ready=%b busy=%h expected 0/01e0", ex_ready, busy_mask); end
    cycle();
    cycle();
    rf_wr1_done = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_no_bypass: got %b expected 0", ex_ready); end
    cycle();
    rf_wr1_done = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL fill_ready_after_pop: got %b expected 1", ex_ready); end
    cycle();
    ex_valid = 1'b0;
    auto_done = 1'b1;
    repeat (30) cycle();
    checks++; if (log_port.size() - base !== 6) begin fails++; $display("[TB] FAIL fill_issue_count: got %0d expected 6", log_port.size() - base); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (log_reg[base+k] !== k + 4) begin fails++; $display("[TB] FAIL fill_order_%0d: got x%0d expected x%0d", k, log_reg[base+k], k + 4); end
    end
    checks++; if (err !== 1'b0 || idle !== 1'b1) begin fails++; $display("[TB] FAIL fill_end: got err=%b idle=%b expected 0/1", err, idle); end
  endtask

  task automatic test_reg0_and_err();
    int base;
    do_reset();
    base = log_port.size();
    ex_valid = 1'b1; ex_reg = 4'd0; ex_value = 32'hDEAD_BEEF;
    #1;
    checks++; if (ex_ready !== 1'b1) begin fails++; $display("[TB] FAIL x0_ready: got %b expected 1", ex_ready); end
    cycle();
    ex_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 16'h0000 || idle !== 1'b1) begin fails++; $display("[TB] FAIL x0_discard: got busy=%h idle=%b expected 0000/1", busy_mask, idle); end
    repeat (6) cycle();
    checks++; if (log_port.size() - base !== 0 || err !== 1'b0) begin fails++; $display("[TB] FAIL x0_no_activity: got %0d issues err=%b expected 0/0", log_port.size() - base, err); end
    auto_done = 1'b0;
    rf_wr2_done = 1'b1;
    cycle();
    rf_wr2_done = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL spurious_done_err: got %b expected 1", err); end
    repeat (3) cycle();
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
    auto_done = 1'b1;
  endtask

  task automatic test_reset_midwrite();
    int base;
    do_reset();
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL err_cleared_by_reset: got %b expected 0", err); end
    auto_done = 1'b0;
    ex_valid = 1'b1;
    for (int r = 10; r <= 13; r++) begin
      ex_reg = 4'(r); ex_value = 32'(r);
      cycle();
    end
    ex_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 16'h3C00 || ex_ready !== 1'b0) begin fails++; $display("[TB] FAIL midwrite_loaded: got busy=%h ready=%b expected 3c00/0", busy_mask, ex_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (idle !== 1'b1 || busy_mask !== 16'h0000 || rf_wr1_value !== 32'd0) begin fails++; $display("[TB] FAIL midwrite_reset: got idle=%b busy=%h val=%h expected 1/0000/0", idle, busy_mask, rf_wr1_value); end
    cycle();
    rst_n = 1'b1;
    pend1 = 1'b0; pend2 = 1'b0;
    auto_done = 1'b1;
    base = log_port.size();
    repeat (15) cycle();
    checks++; if (log_port.size() - base !== 0) begin fails++; $display("[TB] FAIL midwrite_no_replay: got %0d issues expected 0", log_port.size() - base); end
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin fails++; $display("[TB] FAIL midwrite_end: got idle=%b err=%b expected 1/0", idle, err); end
  endtask

  // Main test sequence.
  initial begin
    foreach (rf[i]) rf[i] = 32'd0;
    test_reset();
    test_single_ex();
    test_back_to_back();
    test_ordering();
    test_fill();
    test_reg0_and_err();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
